ioctl_upload_tx: RTL

- SPI-slave transmitter for the ioctl channel, on SPI_SS2; it is the upload (core→ARM) counterpart of the ROM-download path.
- Lets the ARM read core memory (NVRAM, hiscore) byte-serially over SPI_DO.
- Fetches bytes through a variable-latency read handshake and shifts them out MSB first.
- Sits beside data_io in the top-level; the top-level gates SPI_DO with spi_do_oe.

---
 rtl/ioctl_pkg.sv | 26 ++
 rtl/ioctl_upload_tx_if.sv | 28 ++
 rtl/ioctl_upload_tx_spi_sync_edge.sv | 27 ++
 rtl/ioctl_upload_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_pkg.sv
// rtl/ioctl_pkg.sv - shared ioctl command codes, upload FSM states and fill value
package ioctl_pkg;

    // Download-path commands (handled by data_io), kept here so the whole
    // ioctl command space is visible in one place.
    localparam logic [7:0] CMD_FILE_TX     = 8'h53;
    localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;
    localparam logic [7:0] CMD_FILE_INFO   = 8'h56;

    // Upload-path commands.
    localparam logic [7:0] CMD_RX          = 8'h57;
    localparam logic [7:0] CMD_RX_DAT      = 8'h58;

    // Upload FSM states.
    typedef logic [2:0] ioctl_state_t;
    localparam ioctl_state_t ST_IDLE   = 3'd0;
    localparam ioctl_state_t ST_CMD    = 3'd1;
    localparam ioctl_state_t ST_PARAM  = 3'd2;
    localparam ioctl_state_t ST_STREAM = 3'd3;
    localparam ioctl_state_t ST_IGNORE = 3'd4;

    // Byte shifted out when the prefetch buffer is empty at a byte boundary.
    localparam logic [7:0] UNDERRUN_FILL = 8'hFF;

endpackage

// File: rtl/ioctl_upload_tx_if.sv
// rtl/ioctl_upload_tx_if.sv - core memory read handshake for the ioctl upload path
// Ports/signals:
//   ioctl_addr  byte address being fetched (master drives)
//   rd_req      one-cycle read strobe (master drives)
//   rd_ack      one-cycle completion pulse (slave drives)
//   rd_data     read data, valid with rd_ack (slave drives)
interface ioctl_upload_tx_if #(
    parameter int ADDR_W = 25
);
    logic [ADDR_W-1:0] ioctl_addr;
    logic              rd_req;
    logic              rd_ack;
    logic [7:0]        rd_data;

    modport master (
        output ioctl_addr,
        output rd_req,
        input  rd_ack,
        input  rd_data
    );

    modport slave (
        input  ioctl_addr,
        input  rd_req,
        output rd_ack,
        output rd_data
    );
endinterface

// File: rtl/ioctl_upload_tx_spi_sync_edge.sv
// rtl/ioctl_upload_tx_spi_sync_edge.sv - 2-flop synchroniser with rise/fall pulse outputs
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   i_async     asynchronous input
//   o_rise      one-cycle pulse on a synchronised rising edge
//   o_fall      one-cycle pulse on a synchronised falling edge
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);
    // [0] metastability flop, [1] synchronised level, [2] previous level.
    logic [2:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], i_async};
        end
    end

    assign o_rise = r_sync[1] & ~r_sync[2];
    assign o_fall = ~r_sync[1] & r_sync[2];
endmodule

// File: rtl/ioctl_upload_tx.sv
// rtl/ioctl_upload_tx.sv - SPI-slave transmitter streaming core memory to the ARM
// Ports:
//   clk_sys, reset_n          system clock, asynchronous active-low reset
//   SPI_SCK, SPI_SS2, SPI_DI  SPI slave inputs (asynchronous to clk_sys)
//   spi_do, spi_do_oe         slave-out data and its drive enable
//   ioctl_upload              upload session active
//   underrun                  sticky: a byte boundary found no data ready
//   rd_if                     read handshake towards core memory
module ioctl_upload_tx #(
    parameter int         ADDR_W     = 25,
    parameter logic [7:0] CMD_RX     = ioctl_pkg::CMD_RX,
    parameter logic [7:0] CMD_RX_DAT = ioctl_pkg::CMD_RX_DAT
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              SPI_SCK,
    input  logic              SPI_SS2,
    input  logic              SPI_DI,
    output logic              spi_do,
    output logic              spi_do_oe,
    output logic              ioctl_upload,
    output logic              underrun,
    ioctl_upload_tx_if.master rd_if
);
    import ioctl_pkg::ioctl_state_t;
    import ioctl_pkg::ST_IDLE;
    import ioctl_pkg::ST_CMD;
    import ioctl_pkg::ST_PARAM;
    import ioctl_pkg::ST_STREAM;
    import ioctl_pkg::ST_IGNORE;
    import ioctl_pkg::UNDERRUN_FILL;

    logic w_sck_rise;
    logic w_sck_fall;

    spi_sync_edge u_sck_sync (
        .clk     (clk_sys),
        .rst_n   (reset_n),
        .i_async (SPI_SCK),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    // SS2 and DI use the same depth as SCK so all three stay aligned.
    logic [1:0] r_ss_sync;
    logic [1:0] r_di_sync;
    logic       r_ss_prev;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ss_sync <= 2'b00;
            r_di_sync <= 2'b00;
            r_ss_prev <= 1'b0;
        end else begin
            r_ss_sync <= {r_ss_sync[0], SPI_SS2};
            r_di_sync <= {r_di_sync[0], SPI_DI};
            r_ss_prev <= r_ss_sync[1];
        end
    end

    logic w_ss;
    logic w_ss_fall;
    logic w_di;

    assign w_ss      = r_ss_sync[1];
    assign w_ss_fall = ~r_ss_sync[1] & r_ss_prev;
    assign w_di      = r_di_sync[1];

    ioctl_state_t      r_state;
    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_rx_sh;
    logic [7:0]        r_tx_sh;
    logic              r_upload;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_req;
    logic              r_outstanding;
    logic              r_stale;
    logic [7:0]        r_buf;
    logic              r_buf_valid;
    logic              r_underrun;
    logic              r_bnd_pend;

    logic [7:0] w_rx_byte;
    logic       w_ack;
    logic       w_ack_fresh;

    assign w_rx_byte   = {r_rx_sh, w_di};
    // Acks with nothing outstanding (e.g. after a reset) are dropped here.
    assign w_ack       = rd_if.rd_ack & r_outstanding;
    assign w_ack_fresh = w_ack & ~r_stale;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 3'd0;
            r_rx_sh       <= 7'd0;
            r_tx_sh       <= 8'd0;
            r_upload      <= 1'b0;
            r_addr        <= '0;
            r_rd_req      <= 1'b0;
            r_outstanding <= 1'b0;
            r_stale       <= 1'b0;
            r_buf         <= 8'd0;
            r_buf_valid   <= 1'b0;
            r_underrun    <= 1'b0;
            r_bnd_pend    <= 1'b0;
        end else begin
            r_rd_req <= 1'b0;

            // Prefetch completion. A stale ack belongs to a previous session's
            // address, so it is discarded and the fetch reissued at r_addr.
            if (w_ack) begin
                r_outstanding <= 1'b0;
                if (r_stale) begin
                    r_stale       <= 1'b0;
                    r_rd_req      <= 1'b1;
                    r_outstanding <= 1'b1;
                end else begin
                    r_buf       <= rd_if.rd_data;
                    r_buf_valid <= 1'b1;
                end
            end

            if (w_ss) begin
                r_state    <= ST_IDLE;
                r_bit_cnt  <= 3'd0;
                r_bnd_pend <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ss_fall) begin
                            r_state   <= ST_CMD;
                            r_bit_cnt <= 3'd0;
                        end
                    end

                    ST_CMD: begin
                        if (w_sck_rise) begin
                            r_rx_sh   <= w_rx_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (w_rx_byte == CMD_RX) begin
                                    r_state <= ST_PARAM;
                                end else if (w_rx_byte == CMD_RX_DAT && r_upload) begin
                                    r_state    <= ST_STREAM;
                                    r_bnd_pend <= 1'b1;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end
                    end

                    ST_PARAM: begin
                        if (w_sck_rise) begin
                            r_rx_sh   <= w_rx_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= ST_IGNORE;
                                if (w_rx_byte != 8'h00) begin
                                    r_upload    <= 1'b1;
                                    r_addr      <= '0;
                                    r_underrun  <= 1'b0;
                                    r_buf_valid <= 1'b0;
                                    // Only one read may be in flight; an older one
                                    // still pending is marked stale instead.
                                    if (r_outstanding && !w_ack) begin
                                        r_stale <= 1'b1;
                                    end else begin
                                        r_rd_req      <= 1'b1;
                                        r_outstanding <= 1'b1;
                                    end
                                end else begin
                                    r_upload <= 1'b0;
                                end
                            end
                        end
                    end

                    ST_STREAM: begin
                        if (w_sck_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_bnd_pend <= 1'b1;
                            end
                        end
                        if (w_sck_fall) begin
                            if (r_bnd_pend) begin
                                r_bnd_pend <= 1'b0;
                                if (r_buf_valid) begin
                                    r_tx_sh       <= r_buf;
                                    r_buf_valid   <= 1'b0;
                                    r_addr        <= r_addr + 1'b1;
                                    r_rd_req      <= 1'b1;
                                    r_outstanding <= 1'b1;
                                end else if (w_ack_fresh) begin
                                    // Data arriving on the boundary cycle goes
                                    // straight to the shifter.
                                    r_tx_sh       <= rd_if.rd_data;
                                    r_buf_valid   <= 1'b0;
                                    r_addr        <= r_addr + 1'b1;
                                    r_rd_req      <= 1'b1;
                                    r_outstanding <= 1'b1;
                                end else begin
                                    r_tx_sh    <= UNDERRUN_FILL;
                                    r_underrun <= 1'b1;
                                end
                            end else begin
                                r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                            end
                        end
                    end

                    ST_IGNORE: begin
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign spi_do_oe        = (r_state == ST_STREAM);
    assign spi_do           = spi_do_oe ? r_tx_sh[7] : 1'b0;
    assign ioctl_upload     = r_upload;
    assign underrun         = r_underrun;
    assign rd_if.ioctl_addr = r_addr;
    assign rd_if.rd_req     = r_rd_req;
endmodule
